// File: rtl/dqpsk_tx_framer.sv
// Serial transmit framer for the DQPSK modulator: byte FIFO in, one bit per CLK_PER_BIT clocks out.
// Each frame is an alternating preamble, an unscrambled sync word and an additively scrambled payload.
module dqpsk_tx_framer #(
    parameter int          CLK_PER_BIT   = 4,
    parameter int          PREAMBLE_LEN  = 32,
    parameter logic [15:0] SYNC_WORD     = 16'hEB90,
    parameter int          PAYLOAD_BYTES = 32,
    parameter int          FIFO_DEPTH    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       dout,
    output logic       bit_stb,
    output logic       busy,
    output logic       frame_done
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int DW       = $clog2(CLK_PER_BIT + 1);
    localparam int PAY_BITS = PAYLOAD_BYTES * 8;
    localparam int CW       = $clog2(PAY_BITS + PREAMBLE_LEN + 17);

    typedef enum logic [1:0] {IDLE, PREAMBLE, SYNC, PAYLOAD} state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [AW:0]   count;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [CW-1:0] bit_cnt;
    logic [7:0]    shreg;
    logic [6:0]    lfsr;

    logic       tick;
    logic       wr;
    logic       rd;
    logic       byte_start;
    logic       last_payload;
    logic       frame_ready;
    logic [7:0] head;
    logic [6:0] lfsr_in;
    logic       fb;
    logic       data_bit;

    assign tick         = (div == DW'(CLK_PER_BIT - 1));
    assign s_ready      = (count < (AW+1)'(FIFO_DEPTH));
    assign frame_ready  = (count >= (AW+1)'(PAYLOAD_BYTES));
    assign wr           = s_valid & s_ready;
    assign head         = mem[rptr];
    // A new payload byte is popped on the tick that sends its first bit, including the sync->payload tick.
    assign byte_start   = ((state == SYNC) && (bit_cnt == CW'(16))) ||
                          ((state == PAYLOAD) && (bit_cnt != CW'(PAY_BITS)) && (bit_cnt[2:0] == 3'd0));
    assign rd           = tick & byte_start;
    assign last_payload = (state == PAYLOAD) && (bit_cnt == CW'(PAY_BITS));
    assign lfsr_in      = (state == SYNC) ? 7'h7F : lfsr;
    assign fb           = lfsr_in[6] ^ lfsr_in[3];
    assign data_bit     = byte_start ? head[7] : shreg[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            lfsr       <= 7'h7F;
            dout       <= 1'b0;
            busy       <= 1'b0;
            bit_stb    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            bit_stb    <= tick;
            frame_done <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (frame_ready) begin
                            state   <= PREAMBLE;
                            dout    <= 1'b1;
                            bit_cnt <= CW'(1);
                            busy    <= 1'b1;
                        end else begin
                            dout <= 1'b0;
                        end
                    end
                    PREAMBLE: begin
                        if (bit_cnt == CW'(PREAMBLE_LEN)) begin
                            state   <= SYNC;
                            dout    <= SYNC_WORD[15];
                            bit_cnt <= CW'(1);
                        end else begin
                            dout    <= ~bit_cnt[0];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    SYNC: begin
                        if (byte_start) begin
                            state   <= PAYLOAD;
                            dout    <= data_bit ^ fb;
                            lfsr    <= {lfsr_in[5:0], fb};
                            shreg   <= {head[6:0], 1'b0};
                            bit_cnt <= CW'(1);
                        end else begin
                            dout    <= SYNC_WORD[4'd15 - bit_cnt[3:0]];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (last_payload) begin
                            frame_done <= 1'b1;
                            if (frame_ready) begin
                                state   <= PREAMBLE;
                                dout    <= 1'b1;
                                bit_cnt <= CW'(1);
                            end else begin
                                state   <= IDLE;
                                dout    <= 1'b0;
                                busy    <= 1'b0;
                                bit_cnt <= '0;
                            end
                        end else begin
                            dout    <= data_bit ^ fb;
                            lfsr    <= {lfsr_in[5:0], fb};
                            shreg   <= byte_start ? {head[6:0], 1'b0} : {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dqpsk_tx_framer.sv
// Bench for dqpsk_tx_framer: frame-level reference model checked every cycle, plus hand-computed anchors.
module tb_dqpsk_tx_framer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready, dout, bit_stb, busy, frame_done;

    int tests_run = 0;
    int fails = 0;

    dqpsk_tx_framer dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .dout(dout), .bit_stb(bit_stb), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PRBS x^7+x^4+1 from seed 7F: h[0..6] is the all-ones history, h[k] = h[k-7] ^ h[k-4].
    logic prbs [256];
    initial begin
        logic h [263];
        for (int k = 0; k < 263; k++) h[k] = (k < 7) ? 1'b1 : (h[k-7] ^ h[k-4]);
        for (int n = 0; n < 256; n++) prbs[n] = h[n+7];
    end

    // Reference model: whole frame built as a bit list when it starts; FIFO occupancy derived from position.
    logic [7:0] exp_q [$];
    logic       fbits [304];
    logic [7:0] fr_bytes [32];
    int         e = 0;
    bit         in_frame = 0;
    int         m_div = 0;
    logic       exp_dout = 0, exp_stb = 0, exp_busy = 0, exp_done = 0, exp_sready = 1;
    bit         chk_en = 0;

    function automatic int unpopped(input bit inf, input int pos);
        if (!inf) return 0;
        if (pos <= 48) return 32;
        return 32 - (pos - 48 + 7) / 8;
    endfunction

    always @(posedge clk or posedge rst) begin
        int  pre_count;
        bit  wr, tk;
        logic [15:0] sw;
        if (rst) begin
            exp_q.delete();
            in_frame = 0; e = 0; m_div = 0;
            exp_dout = 0; exp_stb = 0; exp_busy = 0; exp_done = 0; exp_sready = 1;
        end else begin
            pre_count = exp_q.size() + unpopped(in_frame, e);
            wr = s_valid && (pre_count < 64);
            tk = (m_div == 3);
            exp_done = 0;
            exp_stb = tk;
            if (tk) begin
                if (in_frame && e == 304) begin
                    in_frame = 0;
                    exp_done = 1;
                end
                if (!in_frame && exp_q.size() >= 32) begin
                    sw = 16'hEB90;
                    for (int j = 0; j < 32; j++) fr_bytes[j] = exp_q.pop_front();
                    for (int j = 0; j < 32; j++) fbits[j] = (j % 2 == 0);
                    for (int j = 0; j < 16; j++) fbits[32+j] = sw[15-j];
                    for (int n = 0; n < 256; n++) fbits[48+n] = fr_bytes[n/8][7-(n%8)] ^ prbs[n];
                    e = 0;
                    in_frame = 1;
                end
                if (in_frame) begin
                    exp_dout = fbits[e];
                    e++;
                    exp_busy = 1;
                end else begin
                    exp_dout = 0;
                    exp_busy = 0;
                end
            end
            if (wr) exp_q.push_back(s_data);
            m_div = (m_div + 1) % 4;
            exp_sready = (exp_q.size() + unpopped(in_frame, e)) < 64;
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("dout", dout, exp_dout);
            chk("bit_stb", bit_stb, exp_stb);
            chk("busy", busy, exp_busy);
            chk("frame_done", frame_done, exp_done);
            chk("s_ready", s_ready, exp_sready);
        end
    end

    task automatic push(input logic [7:0] b);
        int guard;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        guard = 0;
        while (!s_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) chk("push_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_busy(input int bound, input string name);
        int n;
        n = 0;
        while (!busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 1);
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 0);
    endtask

    logic got [304];
    logic [15:0] sync_v;
    logic [7:0]  b0, b1, pb;
    int          n_done, n_stb;

    initial begin
        // Model anchors: first two PRBS bytes from seed 7F.
        #1;
        for (int i = 0; i < 8; i++) pb[7-i] = prbs[i];
        chk("model_prbs_byte0", pb, 8'h0E);
        for (int i = 0; i < 8; i++) pb[7-i] = prbs[8+i];
        chk("model_prbs_byte1", pb, 8'hF2);

        // 1: reset and idle line
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        chk("t1_sready", s_ready, 1);
        n_stb = 0;
        repeat (100) begin
            @(negedge clk);
            if (bit_stb) n_stb++;
            if (busy || dout) chk("t1_idle_line", {busy, dout}, 0);
        end
        chk("t1_stb_count", n_stb, 25);

        // 2: single frame of 0x00..0x1F
        for (int i = 0; i < 32; i++) push(8'(i));
        idle_in();
        wait_busy(40, "t2_start");
        got[0] = dout;
        for (int k = 1; k < 304; k++) begin
            repeat (4) @(negedge clk);
            got[k] = dout;
        end
        repeat (4) @(negedge clk);
        chk("t2_done_at_1216", frame_done, 1);
        chk("t2_busy_drop", busy, 0);
        chk("t2_pre_first", got[0], 1);
        chk("t2_pre_second", got[1], 0);
        chk("t2_pre_last", got[31], 0);
        for (int j = 0; j < 16; j++) sync_v[15-j] = got[32+j];
        chk("t2_sync", sync_v, 16'hEB90);
        for (int j = 0; j < 8; j++) begin
            b0[7-j] = got[48+j];
            b1[7-j] = got[56+j];
        end
        chk("t2_payload_byte0", b0, 8'h0E);
        chk("t2_payload_byte1", b1, 8'hF3);

        // 3: threshold
        for (int i = 0; i < 31; i++) push(8'($urandom_range(0, 255)));
        idle_in();
        repeat (300) @(negedge clk);
        chk("t3_idle_31", busy, 0);
        push(8'($urandom_range(0, 255)));
        idle_in();
        wait_busy(8, "t3_start_next_tick");
        wait_idle(1300, "t3_end");

        // 4: back-to-back with backpressure
        for (int i = 0; i < 64; i++) push(8'($urandom_range(0, 255)));
        @(negedge clk);
        s_valid = 1'b0;
        chk("t4_full", s_ready, 0);
        n_done = 0;
        for (int n = 0; n < 4000 && busy; n++) begin
            @(negedge clk);
            if (frame_done) n_done++;
        end
        chk("t4_two_frames", n_done, 2);
        chk("t4_idle", busy, 0);

        // 5: continuous writes through payload pops
        for (int i = 0; i < 96; i++) push(8'($urandom_range(0, 255)));
        idle_in();
        wait_idle(5000, "t5_end");

        // random gaps: 80 bytes leaves 16 buffered
        for (int i = 0; i < 80; i++) begin
            idle_in();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(8'($urandom_range(0, 255)));
        end
        idle_in();
        wait_busy(100, "rand_start");
        wait_idle(4000, "rand_end");

        // 6: reset during sync
        for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
        idle_in();
        wait_busy(40, "t6_start");
        repeat (32 * 4 + 6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_dout", dout, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_stb", bit_stb, 0);
        chk("t6_rst_done", frame_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("t6_flushed", busy, 0);
        for (int i = 0; i < 32; i++) push(8'($urandom_range(0, 255)));
        idle_in();
        wait_busy(40, "t6_restart");
        chk("t6_first_bit", dout, 1);
        wait_idle(1300, "t6_end");
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
